// File: rtl/branch_fetch_unit.sv
// branch_fetch_unit: F-stage fetch sequencer and D-stage branch resolver for a
// 5-stage MIPS pipeline. Fetches through a req/ack instruction port, parks one
// returned word in a skid buffer while D is stalled, and redirects fetch after
// the branch delay slot.
// Optional macro BRANCH_STAT_EN adds br_total_cnt / br_taken_cnt statistics.
module branch_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        F_req,
  output logic [31:0] F_addr,
  input  logic        F_ack,
  input  logic [31:0] F_instr_in,
  input  logic        D_stall,
  input  logic [2:0]  D_br_type,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_val,
  input  logic        D_CMP_Beq,
  input  logic        D_CMP_Bne,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_valid,
  output logic        D_taken
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0] br_total_cnt,
  output logic [31:0] br_taken_cnt
`endif
);

  localparam logic [2:0] BR_BEQ = 3'd1;
  localparam logic [2:0] BR_BNE = 3'd2;
  localparam logic [2:0] BR_J   = 3'd3;
  localparam logic [2:0] BR_JAL = 3'd4;
  localparam logic [2:0] BR_JR  = 3'd5;

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_n;
  logic [31:0] f_pc, f_pc_n;
  logic [31:0] d_instr_n, d_pc_n;
  logic        d_valid_n;
  logic [31:0] skid_instr, skid_instr_n, skid_pc, skid_pc_n;
  logic        rp, rp_n;
  logic [31:0] rp_pc, rp_pc_n;
  logic        acc, adv, cond;
  logic [31:0] target, next_pc;

  // PC-relative branch target: pc + 4 + sign-extended word offset, wrapping.
  function automatic logic [31:0] rel_target(input logic [31:0] pc,
                                             input logic [15:0] imm);
    logic signed [31:0] off;
    off = $signed({{14{imm[15]}}, imm, 2'b00});
    return pc + 32'd4 + $unsigned(off);
  endfunction

  assign acc     = !D_valid || !D_stall;
  assign adv     = D_valid && !D_stall;
  assign D_taken = adv && cond;
  assign F_addr  = f_pc;
  assign D_PC8   = D_PC + 32'd8;

  // Decode the D instruction's control-flow type into a taken condition and target.
  always_comb begin
    cond   = 1'b0;
    target = D_PC + 32'd4;
    case (D_br_type)
      BR_BEQ: begin cond = D_CMP_Beq; target = rel_target(D_PC, D_imm16); end
      BR_BNE: begin cond = D_CMP_Bne; target = rel_target(D_PC, D_imm16); end
      BR_J, BR_JAL: begin cond = 1'b1; target = {D_PC[31:28], D_imm26, 2'b00}; end
      BR_JR: begin cond = 1'b1; target = D_rs_val; end
      default: ;
    endcase
  end

  // Fetch FSM next state: D/skid loading, fetch PC stepping and redirect tracking.
  always_comb begin
    state_n      = state_q;
    f_pc_n       = f_pc;
    d_instr_n    = D_instr;
    d_pc_n       = D_PC;
    d_valid_n    = D_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    rp_n         = rp;
    rp_pc_n      = rp_pc;
    F_req        = 1'b0;
    // A redirect known now wins; a parked one applies to the delay-slot fetch.
    next_pc      = D_taken ? target : (rp ? rp_pc : f_pc + 32'd4);
    case (state_q)
      FETCH: begin
        F_req = reset;
        if (F_ack) begin
          f_pc_n = next_pc;
          rp_n   = 1'b0;
          if (acc) begin
            d_instr_n = F_instr_in;
            d_pc_n    = f_pc;
            d_valid_n = 1'b1;
          end else begin
            skid_instr_n = F_instr_in;
            skid_pc_n    = f_pc;
            state_n      = HOLD;
          end
        end else begin
          if (adv) d_valid_n = 1'b0;
          if (D_taken) begin
            rp_n    = 1'b1;
            rp_pc_n = target;
          end
        end
      end
      HOLD: begin
        if (!D_stall) begin
          d_instr_n = skid_instr;
          d_pc_n    = skid_pc;
          d_valid_n = 1'b1;
          state_n   = FETCH;
          // The delay slot is already sitting in the skid buffer, so a branch
          // resolving now redirects the very next fetch.
          if (D_taken) f_pc_n = target;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Control and architectural D-stage registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      f_pc    <= PC_RESET;
      D_instr <= '0;
      D_PC    <= '0;
      D_valid <= 1'b0;
      rp      <= 1'b0;
    end else begin
      state_q <= state_n;
      f_pc    <= f_pc_n;
      D_instr <= d_instr_n;
      D_PC    <= d_pc_n;
      D_valid <= d_valid_n;
      rp      <= rp_n;
    end
  end

  // Skid and redirect payloads; only read while their control flags say so.
  always_ff @(posedge clk) begin
    skid_instr <= skid_instr_n;
    skid_pc    <= skid_pc_n;
    rp_pc      <= rp_pc_n;
  end

`ifdef BRANCH_STAT_EN
  // Count resolved control-flow instructions and how many of them redirected.
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_total_cnt <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (adv && (D_br_type != 3'd0) && (D_br_type <= BR_JR))
        br_total_cnt <= br_total_cnt + 32'd1;
      if (D_taken)
        br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Directed bench for branch_fetch_unit with a stream-level reference model.
module tb_branch_fetch_unit;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic        clk, rst_n;
  logic        F_req, F_ack, D_stall, D_valid, D_taken, D_CMP_Beq, D_CMP_Bne;
  logic [31:0] F_addr, F_instr_in, D_rs_val, D_instr, D_PC, D_PC8;
  logic [2:0]  D_br_type;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
`ifdef BRANCH_STAT_EN
  logic [31:0] br_total_cnt, br_taken_cnt;
`endif

  branch_fetch_unit #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .reset(rst_n), .F_req(F_req), .F_addr(F_addr), .F_ack(F_ack),
    .F_instr_in(F_instr_in), .D_stall(D_stall), .D_br_type(D_br_type),
    .D_imm16(D_imm16), .D_imm26(D_imm26), .D_rs_val(D_rs_val),
    .D_CMP_Beq(D_CMP_Beq), .D_CMP_Bne(D_CMP_Bne), .D_instr(D_instr),
    .D_PC(D_PC), .D_PC8(D_PC8), .D_valid(D_valid), .D_taken(D_taken)
`ifdef BRANCH_STAT_EN
    , .br_total_cnt(br_total_cnt), .br_taken_cnt(br_taken_cnt)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  logic seen_taken;

  // program table: control-flow instructions by address
  logic        tbl_on [3];
  logic [31:0] tbl_pc [3];
  logic [2:0]  tbl_type [3];
  logic [15:0] tbl_i16 [3];
  logic [25:0] tbl_i26 [3];
  logic [31:0] tbl_rs [3];
  logic        tbl_eq [3];
  logic        tbl_ne [3];

  // reference model state
  logic [31:0] m_fpc, m_dinstr, m_dpc, m_last, m_after, m_to, m_target;
  logic        m_dv, m_lastv, m_rv, m_taken;
  logic [31:0] m_tot, m_tkn;
  logic [63:0] q[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_tbl(input int i, input logic [31:0] pc, input logic [2:0] ty,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rs, input logic eq, input logic ne);
    tbl_on[i] = 1'b1; tbl_pc[i] = pc; tbl_type[i] = ty; tbl_i16[i] = i16;
    tbl_i26[i] = i26; tbl_rs[i] = rs; tbl_eq[i] = eq; tbl_ne[i] = ne;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < 3; i++) tbl_on[i] = 1'b0;
  endtask

  // Apply inputs for one cycle and derive the expected branch outcome.
  task automatic drive(input logic a, input logic s);
    int k;
    shortint si;
    k = -1;
    for (int i = 0; i < 3; i++)
      if (tbl_on[i] && m_dv && m_dpc == tbl_pc[i]) k = i;
    F_ack = a; D_stall = s; F_instr_in = word(F_addr);
    if (k >= 0) begin
      D_br_type = tbl_type[k]; D_imm16 = tbl_i16[k]; D_imm26 = tbl_i26[k];
      D_rs_val = tbl_rs[k]; D_CMP_Beq = tbl_eq[k]; D_CMP_Bne = tbl_ne[k];
    end else begin
      D_br_type = 3'd0; D_imm16 = 16'h0; D_imm26 = 26'h0;
      D_rs_val = 32'h0; D_CMP_Beq = 1'b0; D_CMP_Bne = 1'b0;
    end
    si = shortint'(D_imm16);
    m_taken = 1'b0;
    m_target = 32'h0;
    case (D_br_type)
      3'd1: begin m_taken = D_CMP_Beq; m_target = m_dpc + 32'd4 + 32'(int'(si) * 4); end
      3'd2: begin m_taken = D_CMP_Bne; m_target = m_dpc + 32'd4 + 32'(int'(si) * 4); end
      3'd3, 3'd4: begin m_taken = 1'b1;
        m_target = (m_dpc & 32'hF000_0000) | (32'(D_imm26) * 32'd4); end
      3'd5: begin m_taken = 1'b1; m_target = D_rs_val; end
      default: ;
    endcase
    if (!(m_dv && !s)) m_taken = 1'b0;
  endtask

  // Advance the model by one clock edge: fetched words queue up in order into D,
  // and the fetch after a taken branch's delay slot goes to its target.
  task automatic model_update();
    logic acc;
    if (!rst_n) begin
      m_fpc = PC_RESET; q.delete(); m_dv = 1'b0; m_dinstr = 32'h0; m_dpc = 32'h0;
      m_rv = 1'b0; m_lastv = 1'b0; m_last = 32'h0; m_tot = 32'h0; m_tkn = 32'h0;
      return;
    end
    acc = !m_dv || !D_stall;
    if (m_dv && !D_stall && D_br_type >= 3'd1 && D_br_type <= 3'd5) m_tot++;
    if (m_taken) begin
      m_tkn++; m_rv = 1'b1; m_after = m_dpc + 32'd4; m_to = m_target;
    end
    if (q.size() == 0 && F_ack) begin
      q.push_back({word(m_fpc), m_fpc});
      m_last = m_fpc; m_lastv = 1'b1;
      if (m_rv && m_last == m_after) begin m_fpc = m_to; m_rv = 1'b0; end
      else m_fpc = m_last + 32'd4;
    end else if (m_rv && m_lastv && m_last == m_after) begin
      m_fpc = m_to; m_rv = 1'b0;
    end
    if (acc) begin
      if (q.size() > 0) begin {m_dinstr, m_dpc} = q.pop_front(); m_dv = 1'b1; end
      else m_dv = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("f_req", F_req, {31'b0, rst_n && q.size() == 0});
    chk("f_addr", F_addr, m_fpc);
    chk("d_valid", D_valid, m_dv);
    chk("d_instr", D_instr, m_dinstr);
    chk("d_pc", D_PC, m_dpc);
    chk("d_pc8", D_PC8, m_dpc + 32'd8);
    chk("d_taken", D_taken, m_taken);
`ifdef BRANCH_STAT_EN
    chk("br_total", br_total_cnt, m_tot);
    chk("br_taken", br_taken_cnt, m_tkn);
`endif
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) if (chk_en) check_all();

  task automatic step(input logic a, input logic s);
    drive(a, s);
    #2 seen_taken = D_taken;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    clr_tbl();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_f_req", F_req, 32'd0);
    chk("rst_f_addr", F_addr, 32'h0000_3000);
    chk("rst_d_valid", D_valid, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; F_ack = 1'b0; D_stall = 1'b0; F_instr_in = 32'h0;
    D_br_type = 3'd0; D_imm16 = 16'h0; D_imm26 = 26'h0; D_rs_val = 32'h0;
    D_CMP_Beq = 1'b0; D_CMP_Bne = 1'b0; m_dv = 1'b0; m_dpc = 32'h0;
    m_taken = 1'b0;
    clr_tbl();

    // sequential fetch with ack every cycle
    do_reset();
    step(1'b1, 1'b0);
    chk("seq_addr1", F_addr, 32'h0000_3004);
    chk("seq_dvalid", D_valid, 32'd1);
    chk("seq_dpc", D_PC, 32'h0000_3000);
    chk("seq_freq", F_req, 32'd1);
    step(1'b1, 1'b0);
    chk("seq_addr2", F_addr, 32'h0000_3008);

    // beq taken, delay slot completes in the resolving cycle
    do_reset();
    set_tbl(0, 32'h3000, 3'd1, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("beq_taken", seen_taken, 32'd1);
    chk("beq_target", F_addr, 32'h0000_3010);
    chk("beq_dslot", D_PC, 32'h0000_3004);
    step(1'b1, 1'b0);
    chk("beq_dpc", D_PC, 32'h0000_3010);

    // bne taken backwards, delay slot returns two cycles late
    do_reset();
    set_tbl(0, 32'h3000, 3'd2, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("bne_taken", seen_taken, 32'd1);
    chk("bne_wait_addr", F_addr, 32'h0000_3004);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("bne_redirect", F_addr, 32'h0000_3000);
    step(1'b1, 1'b0);

    // stall while a word returns: skid buffer holds it
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("hold_freq", F_req, 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("hold_dpc", D_PC, 32'h0000_3004);
    step(1'b0, 1'b0);
    chk("hold_instr", D_instr, word(32'h0000_3008));
    chk("hold_resume", F_addr, 32'h0000_300C);
    chk("hold_freq1", F_req, 32'd1);

    // jump resolving as its delay slot leaves the skid buffer
    do_reset();
    set_tbl(0, 32'h3004, 3'd3, 16'h0, 26'h0000800, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("jskid_taken", seen_taken, 32'd1);
    chk("jskid_target", F_addr, 32'h0000_2000);
    step(1'b1, 1'b0);
    chk("jskid_dpc", D_PC, 32'h0000_2000);

    // jr to 0x4000, j back to 0x3100, jal at 0x3100
    do_reset();
    set_tbl(0, 32'h3000, 3'd5, 16'h0, 26'h0, 32'h0000_4000, 1'b0, 1'b0);
    set_tbl(1, 32'h4000, 3'd3, 16'h0, 26'h0000C40, 32'h0, 1'b0, 1'b0);
    set_tbl(2, 32'h3100, 3'd4, 16'h0, 26'h0000C40, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("jr_target", F_addr, 32'h0000_4000);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("j_target", F_addr, 32'h0000_3100);
    step(1'b1, 1'b0);
    chk("jal_pc8", D_PC8, 32'h0000_3108);
    step(1'b1, 1'b0);
    chk("jal_taken", seen_taken, 32'd1);
    chk("jal_target", F_addr, 32'h0000_3100);

    // reset while a redirect is pending; ack in the reset cycle is ignored
    do_reset();
    set_tbl(0, 32'h3000, 3'd2, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    clr_tbl();
    step(1'b1, 1'b0);
    chk("mid_rst_addr", F_addr, 32'h0000_3000);
    chk("mid_rst_dvalid", D_valid, 32'd0);
`ifdef BRANCH_STAT_EN
    chk("mid_rst_total", br_total_cnt, 32'd0);
    chk("mid_rst_taken", br_taken_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("mid_rst_norp", F_addr, 32'h0000_3004);
    step(1'b1, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
